uart_word_rx: RTL and testbench
===============================

Name: uart_word_rx

Overview:
- Parametrised successor to the team's fixed 8N1, 32-bit word UART receiver.
- Deserialises asynchronous serial frames into bytes, then packs BYTES_PER_WORD bytes into one word.
- Adds configurable bit timing, word width and byte order, framing-error detection and inter-byte timeout resync.
- Sits between the board RxD pin and the pipeline processor's instruction/data loader.

Parameters:
- CLKS_PER_BIT, 64, clock cycles per serial bit; must be ≥ 4.
- BYTES_PER_WORD, 4, bytes packed per output word (1..8).
- MSB_FIRST, 1: first received byte lands in the top byte of the word. 0: first byte lands in bits [7:0].
- TIMEOUT_BITS, 32, idle bit periods after which a partial word is discarded; 0 disables the timeout.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- RxD  input  1  asynchronous serial line; idles high.
- RxD_word_data  output  8*BYTES_PER_WORD  last completed word.
- RxD_word_data_ready  output  1  one-cycle pulse when RxD_word_data updates.
- RxD_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
- RxD_busy  output  1  high while a frame or partial word is in progress.

Behaviour:
- Reset: one clock, synchronous, active-high.
  - All outputs go to 0.
  - FSM goes to IDLE; bit counter, clock counter and byte index clear; partial word is discarded.
  - Reset mid-frame aborts the frame with no pulses.
- Input conditioning: RxD passes through a 2-flop synchroniser; reset value is 1.
- Frame format: 8N1, LSB first. Data bits are sampled at the clock-count midpoint, CLKS_PER_BIT/2 (integer division).
- FSM IDLE: on synchronised RxD = 0 → START, clock counter cleared.
- FSM START: at the midpoint, RxD = 0 → DATA. RxD = 1 → IDLE (glitch rejected; no error).
- FSM DATA: sample one bit per CLKS_PER_BIT cycles; shift right into the byte register. After 8 bits → STOP.
- FSM STOP: at the midpoint:
  - RxD = 1 → byte accepted, FSM → IDLE.
  - RxD = 0 → RxD_frame_err pulses; byte and partial word are discarded; byte index = 0; FSM → WAIT_IDLE.
- FSM WAIT_IDLE: stay until RxD = 1, then → IDLE. This prevents a break condition from being taken as a start bit.
- Word assembly: an accepted byte is written to slot (MSB_FIRST ? BYTES_PER_WORD-1-idx : idx), then idx increments.
- Word completion: when idx reaches BYTES_PER_WORD:
  - RxD_word_data loads the assembled word on the cycle after the stop-bit midpoint.
  - RxD_word_data_ready pulses that same cycle.
  - idx wraps to 0.
- Output hold: RxD_word_data holds its value until the next completed word; it never shows partial bytes.
- Timeout: if idx ≠ 0 and the FSM stays in IDLE for TIMEOUT_BITS*CLKS_PER_BIT cycles, idx clears and the partial word is dropped silently.
- RxD_busy = (state ≠ IDLE) || (idx ≠ 0).
- Back-to-back frames: a start edge arriving directly after the stop midpoint (half a stop bit) must be caught. There is no dead time beyond the stop-bit midpoint.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - Frame becomes 8E1; a PARITY state sits between DATA and STOP.
  - Even-parity mismatch: byte discarded, idx cleared, RxD_frame_err pulses, FSM → WAIT_IDLE (same handling as a framing error).
- Undefined: no PARITY state and no parity logic; behaviour is 8N1 as above.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - DATA_BITS = 8;
  - a function computing the midpoint count from CLKS_PER_BIT.
- Sub-module uart_rx_byte handles synchroniser, FSM and byte deserialiser.
  - Outputs: byte_data[7:0], byte_valid pulse, frame_err pulse.
- Top level holds the word assembler, the timeout counter and the output registers.

Test Plan:
- Defaults (64 clk/bit): send 0x12, 0x34, 0x56, 0x78 back-to-back → one RxD_word_data_ready pulse, RxD_word_data = 0x12345678; no frame_err.
- MSB_FIRST=0: same stream → 0x78563412.
- Send 0xAA, then 0x55 with its stop bit forced low, then 0x11, 0x22, 0x33, 0x44 → one frame_err pulse; no word for 0xAA/0x55; word = 0x11223344.
- 20-clock low glitch on an idle line → no state change past START, no pulses, RxD_busy returns to 0.
- Send 0xDE, 0xAD, idle 40 bit times, then 0xBE, 0xEF, 0x01, 0x02 → partial word dropped; word = 0xBEEF0102.
- Assert rst for 1 cycle mid-way through the second byte, then send 4 fresh bytes 0xCA, 0xFE, 0xBA, 0xBE → all outputs 0 after reset; word = 0xCAFEBABE.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the word-packing UART receiver.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } rx_state_e;

    function automatic int unsigned mid_count(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Serial byte receiver: RxD synchroniser, frame FSM and LSB-first deserialiser.
// Even parity (8E1) is built in when UART_PARITY_EN is defined; otherwise 8N1.
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       idle_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] MidCnt  = CntW'(mid_count(CLKS_PER_BIT));
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rx_meta_q, rx_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
        end
    end

    // Every bit period is counted from its leading edge; sampling happens at MidCnt.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_sync_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == MidCnt && rx_sync_q) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == LastCnt) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (cnt_q == MidCnt) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                end
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (bit_q == BitLast) begin
                        bit_d = '0;
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (cnt_q == MidCnt && ((^shift_q) != rx_sync_q)) begin
                    frame_err_o = 1'b1;
                    state_d     = StWaitIdle;
                    cnt_d       = '0;
                end else if (cnt_q == LastCnt) begin
                    state_d = StStop;
                    cnt_d   = '0;
                end
            end
`endif
            // Leave at the stop midpoint so a back-to-back start edge is not missed.
            StStop: begin
                if (cnt_q == MidCnt) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_o = 1'b1;
                        state_d      = StIdle;
                    end else begin
                        frame_err_o = 1'b1;
                        state_d     = StWaitIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign byte_data_o = shift_q;
    assign idle_o      = (state_q == StIdle);

endmodule

// File: rtl/uart_word_rx.sv
// UART receiver that packs BYTES_PER_WORD bytes into a word, with idle timeout resync.
// Define UART_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_word_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = 64,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter bit          MSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_BITS   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        RxD,
    output logic [8*BYTES_PER_WORD-1:0] RxD_word_data,
    output logic                        RxD_word_data_ready,
    output logic                        RxD_frame_err,
    output logic                        RxD_busy
);

    localparam int unsigned WordW = 8 * BYTES_PER_WORD;
    localparam int unsigned IdxW  = 4;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(BYTES_PER_WORD - 1);
    localparam logic [31:0]     TmoLast = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_err;
    logic             rx_idle;

    logic [WordW-1:0] part_q, part_d;
    logic [WordW-1:0] word_q, word_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [IdxW-1:0]  slot;
    logic [31:0]      tmo_q, tmo_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i       (clk),
        .rst_i       (rst),
        .rx_i        (RxD),
        .byte_data_o (byte_data),
        .byte_valid_o(byte_valid),
        .frame_err_o (byte_err),
        .idle_o      (rx_idle)
    );

    assign slot = MSB_FIRST ? (IdxLast - idx_q) : idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            part_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            tmo_q   <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            part_q  <= part_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        part_d  = part_q;
        word_d  = word_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        if (byte_err) begin
            part_d = '0;
            idx_d  = '0;
            err_d  = 1'b1;
        end else if (byte_valid) begin
            part_d[{slot, 3'b000} +: 8] = byte_data;
            if (idx_q == IdxLast) begin
                word_d  = part_d;
                ready_d = 1'b1;
                part_d  = '0;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (TIMEOUT_BITS != 0 && idx_q != '0 && rx_idle) begin
            // A sender that stalls mid-word loses the partial word rather than misaligning the next one.
            if (tmo_q == TmoLast) begin
                part_d = '0;
                idx_d  = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign RxD_word_data       = word_q;
    assign RxD_word_data_ready = ready_q;
    assign RxD_frame_err       = err_q;
    assign RxD_busy            = !rx_idle || (idx_q != '0);

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: default (MSB-first) and LSB-first instances share one line.
module tb_uart_word_rx;

    localparam int unsigned Cpb = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [31:0] word, word_lsb;
    logic        rdy, rdy_lsb, ferr, ferr_lsb, busy, busy_lsb;

    int n_vec = 0;
    int n_miss = 0;
    int rdy_cnt = 0;
    int rdy_lsb_cnt = 0;
    int err_cnt = 0;
    int b_rdy, b_rdy_lsb, b_err;

    always #5 clk = ~clk;

    uart_word_rx dut (
        .clk                (clk),
        .rst                (rst),
        .RxD                (rxd),
        .RxD_word_data      (word),
        .RxD_word_data_ready(rdy),
        .RxD_frame_err      (ferr),
        .RxD_busy           (busy)
    );

    uart_word_rx #(
        .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk                (clk),
        .rst                (rst),
        .RxD                (rxd),
        .RxD_word_data      (word_lsb),
        .RxD_word_data_ready(rdy_lsb),
        .RxD_frame_err      (ferr_lsb),
        .RxD_busy           (busy_lsb)
    );

    // Pulse counters: a pulse held longer than one cycle counts more than once.
    always @(negedge clk) begin
        if (rdy)     rdy_cnt     <= rdy_cnt + 1;
        if (rdy_lsb) rdy_lsb_cnt <= rdy_lsb_cnt + 1;
        if (ferr)    err_cnt     <= err_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int stop_len);
        rxd = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (Cpb) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_rdy     = rdy_cnt;
        b_rdy_lsb = rdy_lsb_cnt;
        b_err     = err_cnt;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_word", word, 0);
        check_eq("rst_ready", rdy, 0);
        check_eq("rst_err", ferr, 0);
        check_eq("rst_busy", busy, 0);

        // Back-to-back bytes with a shortened stop bit.
        snap();
        send_byte(8'h12, 1'b1, 48);
        send_byte(8'h34, 1'b1, 48);
        send_byte(8'h56, 1'b1, 48);
        send_byte(8'h78, 1'b1, Cpb);
        idle(20);
        check_eq("b2b_ready_cnt", rdy_cnt - b_rdy, 1);
        check_eq("b2b_word", word, 32'h12345678);
        check_eq("lsb_ready_cnt", rdy_lsb_cnt - b_rdy_lsb, 1);
        check_eq("lsb_word", word_lsb, 32'h78563412);
        check_eq("b2b_no_err", err_cnt - b_err, 0);
        check_eq("b2b_busy", busy, 0);

        // Framing error discards the partial word.
        snap();
        send_byte(8'hAA, 1'b1, Cpb);
        send_byte(8'h55, 1'b0, Cpb);
        idle(2 * Cpb);
        check_eq("ferr_idx_clr", busy, 0);
        send_byte(8'h11, 1'b1, Cpb);
        send_byte(8'h22, 1'b1, Cpb);
        send_byte(8'h33, 1'b1, Cpb);
        send_byte(8'h44, 1'b1, Cpb);
        idle(20);
        check_eq("ferr_cnt", err_cnt - b_err, 1);
        check_eq("ferr_ready_cnt", rdy_cnt - b_rdy, 1);
        check_eq("ferr_word", word, 32'h11223344);

        // Short glitch on an idle line.
        snap();
        rxd = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("glitch_busy_hi", busy, 1);
        repeat (5) @(negedge clk);
        idle(100);
        check_eq("glitch_busy_lo", busy, 0);
        check_eq("glitch_no_ready", rdy_cnt - b_rdy, 0);
        check_eq("glitch_no_err", err_cnt - b_err, 0);
        check_eq("glitch_word_hold", word, 32'h11223344);

        // Idle timeout drops a partial word.
        snap();
        send_byte(8'hDE, 1'b1, Cpb);
        send_byte(8'hAD, 1'b1, Cpb);
        idle(1000);
        check_eq("tmo_partial_busy", busy, 1);
        idle(40 * Cpb - 1000);
        check_eq("tmo_dropped", busy, 0);
        send_byte(8'hBE, 1'b1, Cpb);
        send_byte(8'hEF, 1'b1, Cpb);
        send_byte(8'h01, 1'b1, Cpb);
        send_byte(8'h02, 1'b1, Cpb);
        idle(20);
        check_eq("tmo_ready_cnt", rdy_cnt - b_rdy, 1);
        check_eq("tmo_word", word, 32'hBEEF0102);

        // Reset in the middle of the second byte.
        snap();
        send_byte(8'hCA, 1'b1, Cpb);
        rxd = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (Cpb) @(negedge clk);
        end
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_word", word, 0);
        check_eq("mid_rst_ready", rdy, 0);
        check_eq("mid_rst_err", ferr, 0);
        check_eq("mid_rst_busy", busy, 0);
        idle(2 * Cpb);
        send_byte(8'hCA, 1'b1, Cpb);
        send_byte(8'hFE, 1'b1, Cpb);
        send_byte(8'hBA, 1'b1, Cpb);
        send_byte(8'hBE, 1'b1, Cpb);
        idle(20);
        check_eq("post_rst_ready_cnt", rdy_cnt - b_rdy, 1);
        check_eq("post_rst_word", word, 32'hCAFEBABE);
        check_eq("post_rst_no_err", err_cnt - b_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
